i2c_slave_reg_ctrl: RTL and testbench

Register-bank controller that sits behind the `I2C_slave` byte engine and sequences its byte interface into a small addressable register file. The first byte the master writes after the address phase sets a register pointer. Later written bytes are stored at the pointer with auto-increment. Bytes the master reads are served from the pointer, also with auto-increment. A local host port gives the fabric side read/write access to the same registers.

---
 rtl/i2c_slave_reg_ctrl.sv | 151 +++++++++++++++
 tb/tb_i2c_slave_reg_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_reg_ctrl
//  Description : Register-bank controller behind the I2C_slave byte engine.
//                The first written byte of a transaction loads the register
//                pointer. Later written bytes are stored at the pointer, and
//                read bytes are served from it. Both directions
//                auto-increment the pointer. A host port shares the bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_reg_ctrl #(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        slv_data_read,
  output logic [7:0]        slv_data_write,
  input  logic              slv_read_write_flag,
  input  logic              slv_data_finish,
  input  logic              slv_transfer_status,
  input  logic              slv_error,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_collision,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GET_PTR = 2'd1,
    S_WRITE   = 2'd2,
    S_READ    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              status_q;
  logic [7:0]        bank_q [DEPTH];
  logic [7:0]        bank_d [DEPTH];
  logic [7:0]        sdw_q;
  logic [7:0]        rdata_q;
  logic              strobe_q;
  logic              coll_q;
  logic              busy_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic st_rise;
  logic st_fall;
  logic i2c_commit;
  logic host_drop;

  // Edges of the "addressed" flag; a repeated START shows up as fall then rise.
  assign st_rise    = slv_transfer_status & ~status_q;
  assign st_fall    = ~slv_transfer_status & status_q;
  // A data byte that arrives together with a bus error is discarded.
  assign i2c_commit = (state_q == S_WRITE) & slv_data_finish & ~slv_error;
  // Host write loses only when it hits the very register the I2C side writes.
  assign host_drop  = host_we & i2c_commit & (host_addr == ptr_q);

  // Next state and next pointer; errors abort before anything else is looked at.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (slv_error) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (st_rise) state_d = slv_read_write_flag ? S_GET_PTR : S_READ;
        end
        S_GET_PTR: begin
          if (slv_data_finish) begin
            ptr_d   = slv_data_read[ADDR_W-1:0];
            state_d = S_WRITE;
          end
        end
        S_WRITE, S_READ: begin
          if (slv_data_finish) ptr_d = ptr_q + ADDR_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
      if ((state_q != S_IDLE) && st_fall) state_d = S_IDLE;
    end
  end

  // Next bank contents: host write first, then the I2C write overrides it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) bank_d[i] = bank_q[i];
    if (host_we)    bank_d[host_addr] = host_wdata;
    if (i2c_commit) bank_d[ptr_q]     = slv_data_read;
  end

  // Register file storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
    end
  end

  // Controller state, pointer and all registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      status_q  <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      coll_q    <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      status_q  <= slv_transfer_status;
      busy_q    <= (state_d != S_IDLE);
      strobe_q  <= i2c_commit;
      coll_q    <= host_drop;
      if (i2c_commit) wr_addr_q <= ptr_q;
    end
  end

  // Transmit byte tracks the next pointer and next contents, so a pointer
  // advance or a host write to that register is visible one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sdw_q <= RESET_VAL;
    else        sdw_q <= bank_d[ptr_d];
  end

  // Host read port with one clk latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= RESET_VAL;
    else        rdata_q <= bank_q[host_addr];
  end

  assign slv_data_write = sdw_q;
  assign host_rdata     = rdata_q;
  assign host_collision = coll_q;
  assign wr_strobe      = strobe_q;
  assign wr_addr        = wr_addr_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_reg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_slave_reg_ctrl
//  Description : Self-checking bench for i2c_slave_reg_ctrl. A transaction-
//                level model tracks bank contents, pointer and expected
//                outputs; a compare process checks the DUT every cycle and
//                directed checks pin literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_reg_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst_n;
  logic [7:0]        slv_data_read;
  logic [7:0]        slv_data_write;
  logic              slv_read_write_flag;
  logic              slv_data_finish;
  logic              slv_transfer_status;
  logic              slv_error;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;
  logic              host_collision;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;

  i2c_slave_reg_ctrl #(.ADDR_W(ADDR_W), .RESET_VAL(8'h00)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .slv_data_read      (slv_data_read),
    .slv_data_write     (slv_data_write),
    .slv_read_write_flag(slv_read_write_flag),
    .slv_data_finish    (slv_data_finish),
    .slv_transfer_status(slv_transfer_status),
    .slv_error          (slv_error),
    .host_we            (host_we),
    .host_addr          (host_addr),
    .host_wdata         (host_wdata),
    .host_rdata         (host_rdata),
    .host_collision     (host_collision),
    .wr_strobe          (wr_strobe),
    .wr_addr            (wr_addr),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [7:0] m_mem [DEPTH];
  int         m_ptr;
  bit         m_on;        // slave currently addressed and not aborted
  bit         m_wr_dir;    // master is writing in this transaction
  bit         m_have_ptr;  // pointer byte already received in this transaction
  bit         m_prev_st;
  bit         m_rise, m_fall, m_commit;
  int         m_caddr;
  logic [7:0] e_sdw, e_rdata;
  logic [3:0] e_wr_addr;
  bit         e_busy, e_strobe, e_coll, e_sdw_chk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      m_ptr = 0; m_on = 0; m_wr_dir = 0; m_have_ptr = 0; m_prev_st = 0;
      e_sdw = 8'h00; e_rdata = 8'h00; e_wr_addr = 4'h0;
      e_busy = 0; e_strobe = 0; e_coll = 0; e_sdw_chk = 0;
    end else begin
      m_rise    = slv_transfer_status && !m_prev_st;
      m_fall    = !slv_transfer_status && m_prev_st;
      m_prev_st = slv_transfer_status;
      e_rdata   = m_mem[host_addr];
      m_commit  = 0;
      e_coll    = 0;
      if (slv_error) begin
        m_on = 0;
      end else begin
        if (m_on && slv_data_finish) begin
          if (!m_wr_dir) m_ptr = (m_ptr + 1) % DEPTH;
          else if (!m_have_ptr) begin
            m_ptr = int'(slv_data_read) % DEPTH;
            m_have_ptr = 1;
          end else begin
            m_commit = 1;
            m_caddr  = m_ptr;
            m_ptr    = (m_ptr + 1) % DEPTH;
          end
        end
        if (m_on && m_fall) m_on = 0;
        else if (!m_on && m_rise) begin
          m_on = 1; m_wr_dir = slv_read_write_flag; m_have_ptr = 0;
        end
      end
      if (host_we) begin
        if (m_commit && int'(host_addr) == m_caddr) e_coll = 1;
        else m_mem[host_addr] = host_wdata;
      end
      if (m_commit) begin
        m_mem[m_caddr] = slv_data_read;
        e_wr_addr = 4'(m_caddr);
      end
      e_strobe  = m_commit;
      e_busy    = m_on;
      e_sdw_chk = m_on && !m_wr_dir;
      if (e_sdw_chk) e_sdw = m_mem[m_ptr];
    end
  end

  // Strobe log for directed wr_addr sequence checks.
  logic [3:0] strobe_log [$];

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy", {7'd0, busy}, {7'd0, e_busy});
    check("wr_strobe", {7'd0, wr_strobe}, {7'd0, e_strobe});
    check("wr_addr", {4'd0, wr_addr}, {4'd0, e_wr_addr});
    check("host_collision", {7'd0, host_collision}, {7'd0, e_coll});
    check("host_rdata", host_rdata, e_rdata);
    if (e_sdw_chk) check("slv_data_write", slv_data_write, e_sdw);
    if (wr_strobe) strobe_log.push_back(wr_addr);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] d);
    slv_data_read   = d;
    slv_data_finish = 1'b1;
    tick();
    slv_data_finish = 1'b0;
    tick();
    tick();
  endtask

  task automatic start(input logic dir);
    slv_read_write_flag = dir;
    slv_transfer_status = 1'b1;
    tick();
    tick();
  endtask

  task automatic stop();
    slv_transfer_status = 1'b0;
    tick();
    tick();
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic host_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    host_addr = a;
    tick();
    check(name, host_rdata, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, {7'd0, busy}, 8'h00);
    check({tag, " wr_strobe"}, {7'd0, wr_strobe}, 8'h00);
    check({tag, " wr_addr"}, {4'd0, wr_addr}, 8'h00);
    check({tag, " collision"}, {7'd0, host_collision}, 8'h00);
    check({tag, " slv_data_write"}, slv_data_write, 8'h00);
    check({tag, " host_rdata"}, host_rdata, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1;
    slv_data_read = 8'h00; slv_read_write_flag = 1'b0; slv_data_finish = 1'b0;
    slv_transfer_status = 1'b0; slv_error = 1'b0;
    host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Burst write: pointer 3, then A1, B2
    start(1'b1);
    check("busy after entry", {7'd0, busy}, 8'h01);
    xfer(8'h03); xfer(8'hA1); xfer(8'hB2);
    stop();
    check("strobe count", 8'(strobe_log.size()), 8'd2);
    if (strobe_log.size() == 2) begin
      check("strobe addr 0", {4'd0, strobe_log[0]}, 8'h03);
      check("strobe addr 1", {4'd0, strobe_log[1]}, 8'h04);
    end
    check("model ptr burst", 8'(m_ptr), 8'd5);
    host_check("reg3 burst", 4'd3, 8'hA1);
    host_check("reg4 burst", 4'd4, 8'hB2);

    // Combined read: pointer write, repeated START, read 3 bytes
    start(1'b1);
    xfer(8'h03);
    slv_transfer_status = 1'b0;
    tick();
    slv_transfer_status = 1'b1;
    slv_read_write_flag = 1'b0;
    tick();
    tick();
    check("read byte 0", slv_data_write, 8'hA1);
    xfer(8'h00);
    check("read byte 1", slv_data_write, 8'hB2);
    xfer(8'h00);
    check("read byte 2", slv_data_write, 8'h00);
    xfer(8'h00);
    check("model ptr read", 8'(m_ptr), 8'd6);
    stop();
    check("busy after stop", {7'd0, busy}, 8'h00);

    // Wrap: pointer 0F, bytes 11, 22; reg1 preloaded to observe pointer = 1
    host_write(4'd1, 8'h5A);
    start(1'b1);
    xfer(8'h0F); xfer(8'h11); xfer(8'h22);
    stop();
    check("model ptr wrap", 8'(m_ptr), 8'd1);
    host_check("reg15 wrap", 4'd15, 8'h11);
    host_check("reg0 wrap", 4'd0, 8'h22);
    start(1'b0);
    check("read after wrap", slv_data_write, 8'h5A);
    stop();

    // Collision on reg 7, then host reg 7 alongside I2C write to reg 8
    start(1'b1);
    xfer(8'h07);
    slv_data_read = 8'h99; slv_data_finish = 1'b1;
    host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h55;
    tick();
    slv_data_finish = 1'b0; host_we = 1'b0;
    check("collision pulse", {7'd0, host_collision}, 8'h01);
    tick();
    check("collision one clk", {7'd0, host_collision}, 8'h00);
    host_check("reg7 collision", 4'd7, 8'h99);
    slv_data_read = 8'h99; slv_data_finish = 1'b1;
    host_we = 1'b1; host_addr = 4'd7; host_wdata = 8'h55;
    tick();
    slv_data_finish = 1'b0; host_we = 1'b0;
    check("no collision", {7'd0, host_collision}, 8'h00);
    tick();
    stop();
    host_check("reg7 host", 4'd7, 8'h55);
    host_check("reg8 i2c", 4'd8, 8'h99);

    // Error abort on data byte EE
    host_write(4'd10, 8'h3C);
    start(1'b1);
    xfer(8'h0A);
    slv_data_read = 8'hEE; slv_data_finish = 1'b1; slv_error = 1'b1;
    tick();
    slv_data_finish = 1'b0; slv_error = 1'b0;
    check("busy after error", {7'd0, busy}, 8'h00);
    check("no strobe on error", {7'd0, wr_strobe}, 8'h00);
    tick();
    stop();
    host_check("reg10 after error", 4'd10, 8'h3C);
    start(1'b0);
    check("ptr kept after error", slv_data_write, 8'h3C);
    // Host write to reg[pointer] while reading
    host_write(4'd10, 8'h77);
    check("host write in read", slv_data_write, 8'h77);
    tick();
    stop();

    // Reset asserted in the middle of a write transaction
    start(1'b1);
    xfer(8'h02);
    slv_data_read = 8'h44; slv_data_finish = 1'b1;
    tick();
    slv_data_finish = 1'b0;
    check("strobe before reset", {7'd0, wr_strobe}, 8'h01);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid-write reset");
    slv_transfer_status = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) host_check("reg after reset", 4'(i), 8'h00);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
